// File: rtl/adxl362_cntrl.sv
// ADXL362 register sequencer: one request becomes a 3-byte SPI frame (cmd, addr, data/dummy) with CS held low.
// done pulses 1 clk after the third spi_done; requests are refused while busy or while the SPI controller is busy.
module adxl362_cntrl #(
   parameter logic [7:0] CMD_WRITE  = 8'h0A,
   parameter logic [7:0] CMD_READ   = 8'h0B,
   parameter logic [7:0] DUMMY_BYTE = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       write,
   input  logic [7:0] address,
   input  logic [7:0] data_to_send,
   output logic [7:0] data_received,
   output logic       busy,
   output logic       done,
   output logic       spi_start,
   output logic [7:0] spi_data_to_send,
   output logic       spi_hold_cs,
   input  logic       spi_busy,
   input  logic       spi_done,
   input  logic [7:0] spi_data_received
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;

   state_t     state, state_nx;
   logic [1:0] byte_cnt, byte_cnt_nx;
   logic       wr_q, wr_nx;
   logic [7:0] addr_q, addr_nx;
   logic [7:0] wdat_q, wdat_nx;
   logic [7:0] rx_nx, tx_nx;
   logic       busy_nx, done_nx, start_nx, hold_nx;

   function automatic logic [7:0] frame_byte(input logic [1:0] idx, input logic wr,
                                             input logic [7:0] addr, input logic [7:0] wdat);
      case (idx)
         2'd0:    frame_byte = wr ? CMD_WRITE : CMD_READ;
         2'd1:    frame_byte = addr;
         2'd2:    frame_byte = wr ? wdat : DUMMY_BYTE;
         default: frame_byte = DUMMY_BYTE;
      endcase
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         byte_cnt         <= 2'd0;
         wr_q             <= 1'b0;
         addr_q           <= 8'h00;
         wdat_q           <= 8'h00;
         data_received    <= 8'h00;
         busy             <= 1'b0;
         done             <= 1'b0;
         spi_start        <= 1'b0;
         spi_data_to_send <= 8'h00;
         spi_hold_cs      <= 1'b0;
      end else begin
         state            <= state_nx;
         byte_cnt         <= byte_cnt_nx;
         wr_q             <= wr_nx;
         addr_q           <= addr_nx;
         wdat_q           <= wdat_nx;
         data_received    <= rx_nx;
         busy             <= busy_nx;
         done             <= done_nx;
         spi_start        <= start_nx;
         spi_data_to_send <= tx_nx;
         spi_hold_cs      <= hold_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      byte_cnt_nx = byte_cnt;
      wr_nx       = wr_q;
      addr_nx     = addr_q;
      wdat_nx     = wdat_q;
      rx_nx       = data_received;
      tx_nx       = spi_data_to_send;
      hold_nx     = spi_hold_cs;
      start_nx    = 1'b0;

      case (state)
         IDLE: begin
            if (start && !spi_busy) begin
               state_nx    = ISSUE;
               byte_cnt_nx = 2'd0;
               wr_nx       = write;
               addr_nx     = address;
               wdat_nx     = data_to_send;
            end
         end
         ISSUE: state_nx = WAIT;
         WAIT: begin
            if (spi_done) begin
               if (byte_cnt != 2'd2) begin
                  byte_cnt_nx = byte_cnt + 2'd1;
                  state_nx    = ISSUE;
               end else begin
                  state_nx = FIN;
                  if (!wr_q) rx_nx = spi_data_received;
               end
            end
         end
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase

      // Byte and CS-hold are registered on entry to ISSUE so they are stable for the whole byte.
      if (state_nx == ISSUE) begin
         start_nx = 1'b1;
         tx_nx    = frame_byte(byte_cnt_nx, wr_nx, addr_nx, wdat_nx);
         hold_nx  = (byte_cnt_nx != 2'd2);
      end

      busy_nx = (state_nx == ISSUE) || (state_nx == WAIT);
      done_nx = (state_nx == FIN);
   end

endmodule

// File: tb/tb_adxl362_cntrl.sv
// Directed bench for adxl362_cntrl with a behavioural byte-level SPI controller model.
module tb_adxl362_cntrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       write = 1'b0;
   logic [7:0] address = 8'h00;
   logic [7:0] data_to_send = 8'h00;
   logic [7:0] data_received;
   logic       busy, done, spi_start, spi_hold_cs;
   logic [7:0] spi_data_to_send;
   logic       spi_busy;
   logic       spi_done = 1'b0;
   logic [7:0] spi_data_received = 8'h00;

   logic       active = 1'b0;
   logic       force_busy = 1'b0;
   logic [7:0] rx_value = 8'h00;
   int         byte_left = 0;
   int         done_cnt = 0;
   logic [7:0] rec_byte[$];
   logic       rec_hold[$];
   int         checks = 0;
   int         errors = 0;

   assign spi_busy = active | force_busy;

   adxl362_cntrl dut (
      .clk(clk), .rst(rst), .start(start), .write(write), .address(address),
      .data_to_send(data_to_send), .data_received(data_received), .busy(busy), .done(done),
      .spi_start(spi_start), .spi_data_to_send(spi_data_to_send), .spi_hold_cs(spi_hold_cs),
      .spi_busy(spi_busy), .spi_done(spi_done), .spi_data_received(spi_data_received)
   );

   always #5 clk = ~clk;

   // SPI controller model: each byte takes 3 clk after spi_start, then a one-cycle spi_done.
   always @(negedge clk) begin
      if (rst) begin
         active   = 1'b0;
         spi_done = 1'b0;
         byte_left = 0;
      end else begin
         spi_done = 1'b0;
         if (active) begin
            byte_left--;
            if (byte_left == 0) begin
               active            = 1'b0;
               spi_done          = 1'b1;
               spi_data_received = rx_value;
            end
         end else if (spi_start) begin
            rec_byte.push_back(spi_data_to_send);
            rec_hold.push_back(spi_hold_cs);
            active    = 1'b1;
            byte_left = 3;
         end
         if (done) done_cnt++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int windows(input int from);
      int w = 0;
      for (int i = from; i < rec_hold.size(); i++)
         if (i == from || rec_hold[i-1] == 1'b0) w++;
      return w;
   endfunction

   // Raise start and hold it until busy shows acceptance, then scramble the request inputs.
   task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d);
      int k = 0;
      write = w; address = a; data_to_send = d; start = 1'b1;
      @(negedge clk);
      while (!busy && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("accept", {31'd0, busy}, 32'd1);
      start = 1'b0; write = ~w; address = 8'hFF; data_to_send = 8'hEE;
   endtask

   task automatic wait_done(output logic [7:0] rx, output logic b);
      int k = 0;
      while (!done && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("done_seen", {31'd0, done}, 32'd1);
      rx = data_received;
      b  = busy;
   endtask

   logic [7:0] rx;
   logic       b;
   int         d0;
   int         k;

   initial begin
      tick(3);
      check("reset_outputs", {12'd0, data_received, busy, done, spi_start, spi_data_to_send, spi_hold_cs}, 32'd0);
      rst = 1'b0;
      tick(2);
      check("idle_busy", {31'd0, busy}, 32'd0);

      // Read 0x00 returning 0xAD
      rec_byte.delete(); rec_hold.delete(); d0 = done_cnt; rx_value = 8'hAD;
      issue(1'b0, 8'h00, 8'h55);
      wait_done(rx, b);
      check("rd_data", {24'd0, rx}, 32'h0000_00AD);
      check("rd_busy_at_done", {31'd0, b}, 32'd0);
      tick(1);
      check("rd_done_pulse", {31'd0, done}, 32'd0);
      tick(2);
      check("rd_nbytes", rec_byte.size(), 32'd3);
      check("rd_bytes", {8'd0, rec_byte[0], rec_byte[1], rec_byte[2]}, 32'h000B_0000);
      check("rd_holds", {29'd0, rec_hold[0], rec_hold[1], rec_hold[2]}, 32'd6);
      check("rd_ndone", done_cnt - d0, 32'd1);

      // Write 0x02 to 0x2D; data_received must keep 0xAD
      rec_byte.delete(); rec_hold.delete(); d0 = done_cnt; rx_value = 8'h99;
      issue(1'b1, 8'h2D, 8'h02);
      wait_done(rx, b);
      check("wr_data_kept", {24'd0, rx}, 32'h0000_00AD);
      tick(3);
      check("wr_bytes", {8'd0, rec_byte[0], rec_byte[1], rec_byte[2]}, 32'h000A_2D02);
      check("wr_holds", {29'd0, rec_hold[0], rec_hold[1], rec_hold[2]}, 32'd6);
      check("wr_windows", windows(0), 32'd1);
      check("wr_ndone", done_cnt - d0, 32'd1);

      // Start while busy is ignored
      rec_byte.delete(); rec_hold.delete(); d0 = done_cnt; rx_value = 8'h5A;
      issue(1'b0, 8'h10, 8'h00);
      tick(4);
      write = 1'b0; address = 8'h1F; start = 1'b1;
      tick(3);
      start = 1'b0;
      wait_done(rx, b);
      check("sb_data", {24'd0, rx}, 32'h0000_005A);
      tick(20);
      check("sb_nbytes", rec_byte.size(), 32'd3);
      check("sb_addr", {24'd0, rec_byte[1]}, 32'h0000_0010);
      check("sb_ndone", done_cnt - d0, 32'd1);

      // Back-to-back read 0x01 then write 0x13 to 0x2C
      rec_byte.delete(); rec_hold.delete(); d0 = done_cnt; rx_value = 8'h77;
      issue(1'b0, 8'h01, 8'h00);
      wait_done(rx, b);
      check("bb_rd_data", {24'd0, rx}, 32'h0000_0077);
      rx_value = 8'h11;
      issue(1'b1, 8'h2C, 8'h13);
      wait_done(rx, b);
      check("bb_wr_data_kept", {24'd0, rx}, 32'h0000_0077);
      tick(3);
      check("bb_nbytes", rec_byte.size(), 32'd6);
      check("bb_bytes0", {8'd0, rec_byte[0], rec_byte[1], rec_byte[2]}, 32'h000B_0100);
      check("bb_bytes1", {8'd0, rec_byte[3], rec_byte[4], rec_byte[5]}, 32'h000A_2C13);
      check("bb_holds", {26'd0, rec_hold[0], rec_hold[1], rec_hold[2], rec_hold[3], rec_hold[4], rec_hold[5]}, 32'h36);
      check("bb_windows", windows(0), 32'd2);
      check("bb_ndone", done_cnt - d0, 32'd2);

      // Reset during the address byte
      rec_byte.delete(); rec_hold.delete(); rx_value = 8'h3C;
      issue(1'b0, 8'h00, 8'h00);
      k = 0;
      while (rec_byte.size() < 2 && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("rst_reached_byte1", rec_byte.size(), 32'd2);
      tick(1);
      d0 = done_cnt;
      #2 rst = 1'b1;
      #1 check("rst_async_outputs", {12'd0, data_received, busy, done, spi_start, spi_data_to_send, spi_hold_cs}, 32'd0);
      tick(2);
      rst = 1'b0;
      tick(5);
      check("rst_no_done", done_cnt - d0, 32'd0);
      check("rst_idle", {31'd0, busy}, 32'd0);
      rec_byte.delete(); rec_hold.delete(); rx_value = 8'hC3;
      issue(1'b0, 8'h00, 8'h00);
      wait_done(rx, b);
      check("rst_rd_data", {24'd0, rx}, 32'h0000_00C3);
      tick(3);
      check("rst_rd_bytes", {8'd0, rec_byte[0], rec_byte[1], rec_byte[2]}, 32'h000B_0000);

      // spi_busy blocks acceptance
      rec_byte.delete(); rec_hold.delete(); rx_value = 8'h42;
      force_busy = 1'b1;
      write = 1'b0; address = 8'h05; start = 1'b1;
      tick(6);
      check("fb_not_busy", {31'd0, busy}, 32'd0);
      check("fb_no_bytes", rec_byte.size(), 32'd0);
      force_busy = 1'b0;
      tick(1);
      check("fb_accepted", {31'd0, busy}, 32'd1);
      start = 1'b0;
      wait_done(rx, b);
      check("fb_data", {24'd0, rx}, 32'h0000_0042);
      tick(3);
      check("fb_bytes", {8'd0, rec_byte[0], rec_byte[1], rec_byte[2]}, 32'h000B_0500);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/adxl362_cntrl.md
Name: adxl362_cntrl

Overview:
Register-access sequencer that sits in front of the byte-level SPI controller (spi). It turns one register read or write request into the 3-byte ADXL362 frame: command, address, then data or dummy. It drives the SPI controller's start, data_to_send and hold_cs inputs, and keeps CS low across all three bytes. For reads, it returns the third received byte to the requester.

Parameters:
CMD_WRITE, 8'h0A, command byte for a register write
CMD_READ, 8'h0B, command byte for a register read
DUMMY_BYTE, 8'h00, byte sent in slot 2 of a read

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
start  input  1  request strobe; sampled only in IDLE
write  input  1  1 = register write, 0 = register read; sampled with start
address  input  8  register address; sampled with start
data_to_send  input  8  write data; sampled with start
data_received  output  8  read data from the last completed read
busy  output  1  transaction in progress
done  output  1  one-cycle pulse at transaction end
spi_start  output  1  one-cycle start pulse to the SPI controller
spi_data_to_send  output  8  byte presented to the SPI controller
spi_hold_cs  output  1  keep CS low after the current byte
spi_busy  input  1  SPI controller busy
spi_done  input  1  SPI controller byte-complete pulse, one cycle wide
spi_data_received  input  8  byte received by the SPI controller

Behaviour:
- Reset (async, rst=1): state=IDLE, byte_cnt=0, and all outputs 0 (data_received=8'h00, busy=0, done=0, spi_start=0, spi_data_to_send=8'h00, spi_hold_cs=0). Reset mid-transaction aborts immediately; the SPI controller shares rst and also aborts.
- FSM states: IDLE, ISSUE, WAIT, FIN.
- IDLE -> ISSUE: on start=1 && spi_busy=0.
  - Latch write, address and data_to_send into internal registers.
  - Set byte_cnt=0 and busy=1 from the next cycle.
  - start while spi_busy=1 is ignored.
- Byte mux on byte_cnt:
  - 0 = CMD_WRITE or CMD_READ.
  - 1 = latched address.
  - 2 = latched data (write) or DUMMY_BYTE (read).
- Registered outputs driven in ISSUE:
  - spi_data_to_send = byte for byte_cnt.
  - spi_hold_cs = 1 for byte_cnt 0 and 1; 0 for byte_cnt 2.
- ISSUE: spi_start=1 for exactly one cycle, then go to WAIT. spi_data_to_send and spi_hold_cs stay stable until the matching spi_done.
- WAIT: hold until spi_done=1.
  - If byte_cnt<2: byte_cnt+1, go to ISSUE. The next spi_start is exactly one cycle after spi_done, so there is no CS gap.
  - If byte_cnt==2: go to FIN. For a read, capture spi_data_received into data_received on this same edge.
- FIN: done=1 for one cycle, busy=0 on that cycle, then go to IDLE.
  - A new start is accepted the cycle after FIN (back-to-back allowed).
  - Writes leave data_received unchanged.
- Ignored inputs:
  - spi_done outside WAIT.
  - start outside IDLE.
  - Changes to write, address or data_to_send after acceptance.
- busy=1 from the cycle after acceptance through the last WAIT cycle.
- Latency: done is asserted 1 cycle after the third spi_done. The total is 3 SPI byte times plus 4 clk of overhead.

Test Plan:
- Write: start, write=1, address=8'h2D, data=8'h02 -> subunit receives 0A,2D,02 in one CS-low window; spi_hold_cs sequence 1,1,0; a single done pulse; data_received unchanged.
- Read: write=0, address=8'h00, subunit send_value=8'hAD -> MOSI bytes 0B,00,00; data_received=8'hAD on the done cycle; busy falls with done.
- Start while busy: assert start with address=8'h1F mid-transaction -> ignored; only the original 3 bytes are sent; exactly one done.
- Back-to-back: read 8'h01 immediately followed by write 8'h2C data 8'h13 on the cycle after done -> two distinct CS windows; correct bytes in each; two done pulses.
- Reset mid-operation: assert rst during byte 1 WAIT -> all outputs 0 and state IDLE asynchronously; no done; a subsequent read 8'h00 completes normally.
- Start with spi_busy forced to 1 -> not accepted; busy stays 0 until spi_busy=0 and start is re-asserted.
